// File: rtl/video_plane_writer_pkg.sv
// Shared definitions for the bit-plane video writer and display shifter.
// Plane order here must match the shifter's read order.
package video_plane_writer_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int LINE_B_DEF = 32;

  localparam logic [1:0] PLANE_RED   = 2'd0;
  localparam logic [1:0] PLANE_BLUE  = 2'd1;
  localparam logic [1:0] PLANE_GREEN = 2'd2;
  localparam logic [1:0] PLANE_ALTG  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_RED,
    ST_WR_BLUE,
    ST_WR_GREEN
  } wr_state_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] blue;
    logic [7:0] green;
  } plane_group_t;

  function automatic logic [1:0] green_plane(
    input logic altg
  );
    return altg ? PLANE_ALTG : PLANE_GREEN;
  endfunction

endpackage

// File: rtl/video_plane_packer.sv
// Packs the serial RGB stream into plane bytes and holds one
// complete group for the writer FSM.
module video_plane_packer
  import video_plane_writer_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic         de,
  input  logic         r,
  input  logic         g,
  input  logic         b,
  input  logic         vsync,
  input  logic         free,
  output plane_group_t hold,
  output logic         hold_valid,
  output logic         drop,
  output logic         overflow
);

  logic [7:0]   sr_r;
  logic [7:0]   sr_g;
  logic [7:0]   sr_b;
  logic [2:0]   count;
  logic [2:0]   pad;
  logic         de_q;
  logic         complete;
  logic         flush;
  logic         push;
  plane_group_t group;

  always_comb begin
    complete = ce && de && (count == 3'd7) && !vsync;
    flush    = ce && !de && de_q && (count != 3'd0) && !vsync;
    pad      = 3'd0 - count;
    group    = '0;
    if (flush) begin
      // left-justify the partial byte so unused pixels read as black
      group.red   = sr_r << pad;
      group.blue  = sr_b << pad;
      group.green = sr_g << pad;
    end else begin
      group.red   = {sr_r[6:0], r};
      group.blue  = {sr_b[6:0], b};
      group.green = {sr_g[6:0], g};
    end
    push = (complete || flush) && (!hold_valid || free);
    drop = (complete || flush) && hold_valid && !free;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_r       <= '0;
      sr_g       <= '0;
      sr_b       <= '0;
      count      <= '0;
      de_q       <= 1'b0;
      hold       <= '0;
      hold_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (vsync) begin
        sr_r  <= '0;
        sr_g  <= '0;
        sr_b  <= '0;
        count <= '0;
      end else if (ce && de) begin
        sr_r  <= {sr_r[6:0], r};
        sr_g  <= {sr_g[6:0], g};
        sr_b  <= {sr_b[6:0], b};
        count <= count + 3'd1;
      end else if (flush) begin
        sr_r  <= '0;
        sr_g  <= '0;
        sr_b  <= '0;
        count <= '0;
      end

      if (ce) de_q <= de;

      if (vsync) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;

      if (push) begin
        hold       <= group;
        hold_valid <= 1'b1;
      end else if (free) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/video_plane_writer.sv
// Writes packed plane bytes to video RAM through a req/ack port,
// one byte per plane, red then blue then green.
module video_plane_writer
  import video_plane_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_B = LINE_B_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              vsync,
  input  logic              de,
  input  logic              r,
  input  logic              g,
  input  logic              b,
  input  logic              altg,
  output logic              req,
  input  logic              ack,
  output logic [1:0]        a,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        d,
  output logic              overflow
);

  if (LINE_B <= 0 || (LINE_B * 8) > (1 << ADDR_W))
  begin : g_bad_line
    $error("LINE_B does not fit in one plane");
  end

  wr_state_t         state;
  wr_state_t         state_nx;
  plane_group_t      hold;
  logic              hold_valid;
  logic              drop;
  logic              free;
  logic              busy;
  logic              vs_pend;
  logic [ADDR_W-1:0] skip;

  video_plane_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .de         (de),
    .r          (r),
    .g          (g),
    .b          (b),
    .vsync      (vsync),
    .free       (free),
    .hold       (hold),
    .hold_valid (hold_valid),
    .drop       (drop),
    .overflow   (overflow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    a        = PLANE_RED;
    d        = 8'h00;
    free     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (hold_valid) state_nx = ST_WR_RED;
      end
      ST_WR_RED: begin
        req = 1'b1;
        a   = PLANE_RED;
        d   = hold.red;
        if (ack) state_nx = ST_WR_BLUE;
      end
      ST_WR_BLUE: begin
        req = 1'b1;
        a   = PLANE_BLUE;
        d   = hold.blue;
        if (ack) state_nx = ST_WR_GREEN;
      end
      ST_WR_GREEN: begin
        req = 1'b1;
        a   = green_plane(altg);
        d   = hold.green;
        if (ack) begin
          state_nx = ST_IDLE;
          free     = 1'b1;
        end
      end
    endcase
  end

  assign busy = (state != ST_IDLE) || hold_valid;

  // skip counts dropped groups so later bytes keep their column
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      skip    <= '0;
      vs_pend <= 1'b0;
    end else if (free) begin
      if (vsync)        addr <= '0;
      else if (vs_pend) addr <= skip;
      else              addr <= addr + skip + ADDR_W'(1);
      skip    <= '0;
      vs_pend <= 1'b0;
    end else if (vsync) begin
      if (busy) vs_pend <= 1'b1;
      else      addr    <= '0;
      skip <= '0;
    end else if (drop) begin
      skip <= skip + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_video_plane_writer.sv
// Scoreboard bench for video_plane_writer.
module tb_video_plane_writer;

  localparam int AW = 13;

  logic          clock = 1'b0;
  logic          reset;
  logic          ce;
  logic          vsync;
  logic          de;
  logic          r;
  logic          g;
  logic          b;
  logic          altg;
  logic          req;
  logic          ack;
  logic [1:0]    a;
  logic [AW-1:0] addr;
  logic [7:0]    d;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [22:0] exp_q[$];
  int          wr_cyc[$];
  logic        stall_q = 1'b0;
  logic [22:0] stall_v;

  video_plane_writer #(.ADDR_W(AW), .LINE_B(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .vsync    (vsync),
    .de       (de),
    .r        (r),
    .g        (g),
    .b        (b),
    .altg     (altg),
    .req      (req),
    .ack      (ack),
    .a        (a),
    .addr     (addr),
    .d        (d),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && req && ack) begin
      stall_q = 1'b0;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {9'd0, a, addr, d}, 32'hFFFFFFFF);
      end else begin
        chk("write", {9'd0, a, addr, d},
            {9'd0, exp_q.pop_front()});
      end
    end else if (!reset && req) begin
      if (stall_q) chk("stall_stable", {9'd0, a, addr, d},
                       {9'd0, stall_v});
      stall_q = 1'b1;
      stall_v = {a, addr, d};
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pixel(input logic pr, input logic pg,
                       input logic pb);
    ce = 1'b1;
    de = 1'b1;
    r  = pr;
    g  = pg;
    b  = pb;
    tick();
  endtask

  task automatic idle_ce();
    ce = 1'b1;
    de = 1'b0;
    r  = 1'b0;
    g  = 1'b0;
    b  = 1'b0;
    tick();
  endtask

  task automatic send_group(input logic [7:0] rr,
                            input logic [7:0] gg,
                            input logic [7:0] bb);
    for (int i = 7; i >= 0; i--) pixel(rr[i], gg[i], bb[i]);
    idle_ce();
  endtask

  task automatic push_exp(input logic [7:0] rr,
                          input logic [7:0] gg,
                          input logic [7:0] bb,
                          input logic       alt,
                          input logic [AW-1:0] ad);
    exp_q.push_back({2'd0, ad, rr});
    exp_q.push_back({2'd1, ad, bb});
    exp_q.push_back({alt ? 2'd3 : 2'd2, ad, gg});
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (exp_q.size() != 0 || req); n++)
      tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_req();
    for (int n = 0; n < 50 && !req; n++) tick();
    chk("wait_req", {31'd0, req}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    ce    = 1'b0;
    vsync = 1'b0;
    de    = 1'b0;
    r     = 1'b0;
    g     = 1'b0;
    b     = 1'b0;
    altg  = 1'b0;
    ack   = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_a", {30'd0, a}, 0);
    chk("rst_addr", {19'd0, addr}, 0);
    chk("rst_d", {24'd0, d}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    reset = 1'b0;
    tick();

    // basic group, back-to-back writes
    ack = 1'b1;
    wr_cyc.delete();
    push_exp(8'hFF, 8'h00, 8'hAA, 1'b0, 13'd0);
    send_group(8'hFF, 8'h00, 8'hAA);
    drain();
    chk("t1_span", wr_cyc[2] - wr_cyc[0], 2);
    chk("t1_addr", {19'd0, addr}, 1);

    // alternate green bank
    altg = 1'b1;
    push_exp(8'hFF, 8'h00, 8'hAA, 1'b1, 13'd1);
    send_group(8'hFF, 8'h00, 8'hAA);
    drain();
    altg = 1'b0;
    chk("t2_addr", {19'd0, addr}, 2);

    // partial flush, then a full group proves count cleared
    push_exp(8'hE0, 8'h00, 8'h00, 1'b0, 13'd2);
    pixel(1'b1, 1'b0, 1'b0);
    pixel(1'b1, 1'b0, 1'b0);
    pixel(1'b1, 1'b0, 1'b0);
    idle_ce();
    drain();
    push_exp(8'h0F, 8'hF0, 8'h3C, 1'b0, 13'd3);
    send_group(8'h0F, 8'hF0, 8'h3C);
    drain();
    chk("t3_addr", {19'd0, addr}, 4);

    // stall across two completions: second group dropped
    ack = 1'b0;
    push_exp(8'h11, 8'h22, 8'h33, 1'b0, 13'd4);
    send_group(8'h11, 8'h22, 8'h33);
    send_group(8'h44, 8'h55, 8'h66);
    repeat (4) tick();
    chk("t4_ovf", {31'd0, overflow}, 1);
    chk("t4_addr", {19'd0, addr}, 4);
    chk("t4_a", {30'd0, a}, 0);
    ack = 1'b1;
    drain();
    push_exp(8'h77, 8'h88, 8'h99, 1'b0, 13'd6);
    send_group(8'h77, 8'h88, 8'h99);
    drain();
    chk("t4_addr_after", {19'd0, addr}, 7);
    chk("t4_ovf_sticky", {31'd0, overflow}, 1);

    // vsync during WR_BLUE
    ack = 1'b0;
    push_exp(8'hC3, 8'h5A, 8'h81, 1'b0, 13'd7);
    send_group(8'hC3, 8'h5A, 8'h81);
    wait_req();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t5_blue", {30'd0, a}, 1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("t5_ovf", {31'd0, overflow}, 0);
    chk("t5_addr_held", {19'd0, addr}, 7);
    ack = 1'b1;
    drain();
    chk("t5_addr", {19'd0, addr}, 0);
    push_exp(8'h12, 8'h34, 8'h56, 1'b0, 13'd0);
    send_group(8'h12, 8'h34, 8'h56);
    drain();
    chk("t5_addr_next", {19'd0, addr}, 1);

    // reset mid WR_RED
    ack = 1'b0;
    send_group(8'hFF, 8'hFF, 8'hFF);
    wait_req();
    chk("t6_red", {30'd0, a}, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_req_async", {31'd0, req}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("t6_addr", {19'd0, addr}, 0);
    ack = 1'b1;
    push_exp(8'hA5, 8'h0F, 8'hF0, 1'b0, 13'd0);
    send_group(8'hA5, 8'h0F, 8'hF0);
    drain();
    chk("t6_addr_after", {19'd0, addr}, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
